// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide controller owning HI/LO with a fixed-latency busy window
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        wait_req,
  output logic        done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q, hi_n, lo_n;
  logic [31:0] abs_a, abs_b, uq, ur, q, r;
  logic [63:0] ea, eb, prod;
  logic done_n, go, sgn, neg_a;
  assign busy = state == BUSY;
  assign wait_req = busy | (start & ~op[2]);
  assign go = state == IDLE & start & ~op[2];
  assign sgn = ~op_q[0];
  // Sign- or zero-extend, then a plain 64-bit multiply gives the right product for both flavours
  assign ea = {{32{sgn & a_q[31]}}, a_q};
  assign eb = {{32{sgn & b_q[31]}}, b_q};
  assign prod = ea * eb;
  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign neg_a = sgn & a_q[31];
  assign abs_a = neg_a ? -a_q : a_q;
  assign abs_b = (sgn & b_q[31]) ? -b_q : b_q;
  assign uq = abs_b == 32'd0 ? 32'd0 : abs_a / abs_b;
  assign ur = abs_b == 32'd0 ? 32'd0 : abs_a % abs_b;
  assign q = (sgn & (a_q[31] ^ b_q[31])) ? -uq : uq;
  assign r = neg_a ? -ur : ur;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hi_n = HI;
    lo_n = LO;
    done_n = 1'b0;
    if (state == BUSY) begin
      cnt_n = cnt - 4'd1;
      if (cnt == 4'd1) begin
        state_n = IDLE;
        done_n = 1'b1;
        if (!op_q[1]) {hi_n, lo_n} = prod;
        else if (b_q != 32'd0) {hi_n, lo_n} = {r, q};
      end
    end else if (start) begin
      if (!op[2]) begin
        state_n = BUSY;
        cnt_n = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (op[1:0] == 2'd0) hi_n = d1;
      else if (op[1:0] == 2'd1) lo_n = d1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      op_q <= 2'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      HI <= 32'd0;
      LO <= 32'd0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      HI <= hi_n;
      LO <= lo_n;
      done <= done_n;
      if (go) begin
        op_q <= op[1:0];
        a_q <= d1;
        b_q <= d2;
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and randomized checks of mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
  logic clk = 1'b0, rst, start;
  logic [2:0] op;
  logic [31:0] d1, d2, HI, LO;
  logic busy, wait_req, done;
  logic [31:0] mdl_hi, mdl_lo;
  int total = 0, passed = 0;

  mdu_sequencer dut (.clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
                     .HI(HI), .LO(LO), .busy(busy), .wait_req(wait_req), .done(done));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, b, hi, lo);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: return (b == 0) ? {hi, lo} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (b == 0) ? {hi, lo} : {a % b, a / b};
      default: return {hi, lo};
    endcase
  endfunction

  // Issues a mult/div in the current cycle; icyc (1..n) injects a start with op iop while busy.
  // Returns in the done cycle with start low.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, b, input int icyc, input logic [2:0] iop);
    int n;
    logic [63:0] e;
    n = o[1] ? 10 : 5;
    e = ref_res(o, a, b, mdl_hi, mdl_lo);
    start = 1'b1; op = o; d1 = a; d2 = b;
    #1;
    chk("wait_req_issue", {65'd0, wait_req}, 66'd1);
    chk("issue_cycle", {1'b0, busy, HI, LO}, {2'b00, mdl_hi, mdl_lo});
    tick();
    start = 1'b0; d1 = $urandom; d2 = $urandom;
    for (int k = 1; k <= n; k++) begin
      if (k == icyc) begin
        start = 1'b1; op = iop; d1 = $urandom; d2 = $urandom;
      end
      #1;
      chk("busy_window", {busy, done, HI, LO}, {2'b10, mdl_hi, mdl_lo});
      chk("wait_req_busy", {65'd0, wait_req}, 66'd1);
      tick();
      start = 1'b0;
    end
    {mdl_hi, mdl_lo} = e;
    chk("done_cycle", {busy, done, HI, LO}, {2'b01, mdl_hi, mdl_lo});
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; d1 = v; d2 = $urandom;
    #1;
    chk("wait_req_mt", {65'd0, wait_req}, 66'd0);
    tick();
    start = 1'b0;
    if (o == 3'd4) mdl_hi = v;
    if (o == 3'd5) mdl_lo = v;
    chk("mt_apply", {busy, done, HI, LO}, {2'b00, mdl_hi, mdl_lo});
  endtask

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op = 3'd0; d1 = 32'd0; d2 = 32'd0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", {busy, done, HI, LO}, 66'd0);
    chk("reset_wait_req", {65'd0, wait_req}, 66'd0);

    run_md(3'd0, 32'hFFFFFFFD, 32'd2, 0, 3'd0);
    chk("mult_neg3x2", {HI, LO}, {2'b00, 32'hFFFFFFFF, 32'hFFFFFFFA});
    tick();
    chk("done_one_cycle", {65'd0, done}, 66'd0);

    run_md(3'd3, 32'd7, 32'd2, 0, 3'd0);
    chk("divu_7_2", {HI, LO}, {2'b00, 32'd1, 32'd3});
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, 0, 3'd0);
    chk("div_neg7_2", {HI, LO}, {2'b00, 32'hFFFFFFFF, 32'hFFFFFFFD});

    tick();
    mt(3'd4, 32'h12345678);
    chk("mthi_value", {34'd0, HI}, {34'd0, 32'h12345678});
    mt(3'd5, 32'h9ABCDEF0);
    chk("mtlo_value", {34'd0, LO}, {34'd0, 32'h9ABCDEF0});

    mt(3'd4, 32'hAAAA);
    mt(3'd5, 32'h5555);
    run_md(3'd2, 32'd5, 32'd0, 0, 3'd0);
    chk("div_by_zero_keep", {HI, LO}, {2'b00, 32'hAAAA, 32'h5555});

    mt(3'd6, 32'hDEAD);
    run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 3'd5);
    chk("multu_max_ignore_mtlo", {HI, LO}, {2'b00, 32'hFFFFFFFE, 32'h00000001});
    mt(3'd4, 32'hCAFEF00D);

    start = 1'b1; op = 3'd1; d1 = 32'hFFFFFFFF; d2 = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    chk("abort_reset", {busy, done, HI, LO}, 66'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_done", {busy, done, HI, LO}, 66'd0);
    end

    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0);
    chk("div_overflow", {HI, LO}, {2'b00, 32'd0, 32'h80000000});

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      if (o < 3'd4) run_md(o, a, b, int'($urandom_range(0, o[1] ? 10 : 5)), 3'($urandom_range(0, 7)));
      else mt(o, a);
    end
    tick();
    chk("final_idle", {busy, done, HI, LO}, {2'b00, mdl_hi, mdl_lo});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the E stage. It owns the HI/LO registers and sequences mult/multu/div/divu over a fixed-latency busy window.
- It applies mthi/mtlo immediately.
- It supplies `busy` and `wait_req` to the hazard logic, so that md-class instructions in D stall while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy length for mult/multu. Legal range 1..15.
- DIV_CYCLES, 10, busy length for div/divu. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: one clock, synchronous, active-high
- start  input  1  E-stage request; op, d1 and d2 are sampled on the rising edge when high
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op
- d1  input  32  rs operand (already forwarded)
- d2  input  32  rt operand (already forwarded)
- HI  output  32  HI register
- LO  output  32  LO register
- busy  output  1  registered; high while a mult/div is in progress
- wait_req  output  1  combinational: busy | (start & op<=3); to the stall unit
- done  output  1  registered one-cycle pulse when HI/LO take a mult/div result

Behaviour:
- Reset (rst high at a posedge):
  - HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0, operand latches=0.
  - Reset aborts any operation in progress; no partial result is written.
- States:
  - IDLE: no operation in progress.
  - BUSY: counter active, HI/LO frozen.
- IDLE transitions, start high in cycle 0:
  - op 0..3: latch op, d1 and d2; load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); go to BUSY.
    - busy is high in cycles 1..N. HI/LO keep their old values in cycles 0..N.
    - On the posedge ending cycle N, HI/LO are written with the result and busy falls.
    - done is high in cycle N+1 only; state is IDLE in cycle N+1.
  - op 4: HI<=d1 at that posedge; visible in cycle 1. No busy, no done.
  - op 5: LO<=d1 at that posedge; visible in cycle 1. No busy, no done.
  - op 6/7: no effect.
- BUSY transitions:
  - The counter decrements each cycle. At counter==1, go to IDLE and commit the result.
  - start asserted while busy is ignored, whatever op is. The stall unit must prevent this; the block itself must not corrupt state.
- Results, computed from the latched operands only; later changes on d1/d2 are irrelevant:
  - mult: {HI,LO} = signed d1 × signed d2 (64-bit).
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div/divu with d2==0: full latency, busy and done behave normally, HI/LO unchanged.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Back-to-back requests:
  - A new start is accepted in cycle N+1, the done cycle, exactly as in IDLE.
  - A mthi/mtlo in cycle N+1 overwrites the just-written value.
- wait_req:
  - Purely combinational from start, op and busy.
  - It must never depend on d1/d2, so the stall path has no data loop.

Test Plan:
- Reset, then start in cycle 0 with op=mult, d1=0xFFFFFFFD (−3), d2=2 → busy high in cycles 1..5; HI/LO=0 through cycle 5; cycle 6 shows HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0, done=1; cycle 7 done=0.
- op=divu, d1=7, d2=2 → busy high in cycles 1..10; cycle 11 shows LO=3, HI=1, done=1. Then op=div, d1=0xFFFFFFF9 (−7), d2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- op=mthi, d1=0x12345678, then next cycle op=mtlo, d1=0x9ABCDEF0 → HI=0x12345678 in cycle 1, LO=0x9ABCDEF0 in cycle 2; busy stays 0 throughout; wait_req=0 for both.
- op=div, d1=5, d2=0, with HI=0xAAAA and LO=0x5555 preloaded → busy lasts 10 cycles, done pulses, HI/LO remain 0xAAAA/0x5555.
- op=multu, 0xFFFFFFFF×0xFFFFFFFF, then start op=mtlo d1=1 at cycle 3 → mtlo is ignored; cycle 6 shows HI=0xFFFFFFFE, LO=0x00000001. Repeat, asserting rst in cycle 3 → from cycle 4, busy=0, HI=LO=0; no done pulse ever appears.
